// File: rtl/hs_pkg.sv
// Shared definitions for the req/ack snapshot block: capture FSM states,
// MODE selector values and default parameter values.
package hs_pkg;

   localparam int MODE_LEGACY = 0;
   localparam int MODE_REQACK = 1;

   localparam int DEF_CH_COUNT  = 12;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_MAX_RETRY = 3;
   localparam int DEF_CNT_W     = 8;
   localparam int DEF_MODE      = MODE_REQACK;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SAMPLE_A = 3'd1,
      SAMPLE_B = 3'd2,
      COMMIT   = 3'd3,
      ACK_HOLD = 3'd4
   } hs_state_t;

endpackage

// File: rtl/hs_rise_det.sv
// Request edge detector: registers the request and flags a low-to-high change.
// req_q resets high so a request held through reset never looks like a rise.
module hs_rise_det (
   input  logic clk,
   input  logic reset,
   input  logic req,
   output logic rise
);

   logic req_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         req_q <= 1'b1;
      end else begin
         req_q <= req;
      end
   end

   assign rise = req & ~req_q;

endmodule

// File: rtl/hs_snapshot_n.sv
// Multi-channel coherent snapshot register with a req/ack handshake; the live
// data is re-sampled until two consecutive samples agree on the masked channels.
module hs_snapshot_n
   import hs_pkg::*;
#(
   parameter int CH_COUNT  = DEF_CH_COUNT,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_RETRY = DEF_MAX_RETRY,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int MODE      = DEF_MODE
) (
   input  logic                       reloj_nex,
   input  logic                       reset,
   input  logic [CH_COUNT*DATA_W-1:0] datos_a,
   input  logic [CH_COUNT-1:0]        ch_mask,
   input  logic                       hs_req,
   output logic                       hs_ack,
   output logic [CH_COUNT*DATA_W-1:0] datos_o,
   output logic                       busy,
   output logic                       snap_valid,
   output logic                       snap_err,
   output logic [CNT_W-1:0]           snap_count
);

   localparam int TOT_W   = CH_COUNT * DATA_W;
   localparam int RETRY_W = $clog2(MAX_RETRY + 2);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   hs_state_t          state;
   logic [TOT_W-1:0]   shadow;
   logic [TOT_W-1:0]   mask_bits;
   logic [RETRY_W-1:0] retry_cnt;
   logic               err_nx;
   logic               rise;
   logic               stable;

   hs_rise_det u_rise (
      .clk   (reloj_nex),
      .reset (reset),
      .req   (hs_req),
      .rise  (rise)
   );

   // Each mask bit widened over its channel so whole words can be merged at once.
   for (genvar i = 0; i < CH_COUNT; i++) begin : g_mask
      assign mask_bits[i*DATA_W +: DATA_W] = {DATA_W{ch_mask[i]}};
   end

   assign stable = ((datos_a ^ shadow) & mask_bits) == '0;

   always_ff @(posedge reloj_nex) begin
      if (reset) begin
         state      <= IDLE;
         shadow     <= '0;
         retry_cnt  <= '0;
         err_nx     <= 1'b0;
         datos_o    <= '0;
         hs_ack     <= 1'b0;
         busy       <= 1'b0;
         snap_valid <= 1'b0;
         snap_err   <= 1'b0;
         snap_count <= '0;
      end else if (MODE == MODE_LEGACY) begin
         if (hs_req) begin
            datos_o    <= (datos_o & ~mask_bits) | (datos_a & mask_bits);
            snap_valid <= 1'b1;
         end
         hs_ack <= hs_req;
         if (rise) begin
            snap_count <= snap_count + CNT_W'(1);
         end
      end else begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state <= SAMPLE_A;
                  busy  <= 1'b1;
               end
            end
            SAMPLE_A: begin
               shadow    <= datos_a;
               retry_cnt <= '0;
               state     <= SAMPLE_B;
            end
            // On exhaustion the newest sample is committed and flagged as suspect.
            SAMPLE_B: begin
               if (stable) begin
                  err_nx <= 1'b0;
                  state  <= COMMIT;
               end else begin
                  shadow <= datos_a;
                  if (retry_cnt < RETRY_MAX) begin
                     retry_cnt <= retry_cnt + RETRY_W'(1);
                  end else begin
                     err_nx <= 1'b1;
                     state  <= COMMIT;
                  end
               end
            end
            COMMIT: begin
               datos_o    <= (datos_o & ~mask_bits) | (shadow & mask_bits);
               snap_valid <= 1'b1;
               snap_err   <= err_nx;
               snap_count <= snap_count + CNT_W'(1);
               hs_ack     <= 1'b1;
               state      <= ACK_HOLD;
            end
            ACK_HOLD: begin
               if (!hs_req) begin
                  hs_ack <= 1'b0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hs_snapshot_n.sv
// Randomized and directed bench for hs_snapshot_n in req/ack mode, checked
// against a transaction-level prediction of each capture.
module tb_hs_snapshot_n;
   import hs_pkg::*;

   localparam int CH = 12;
   localparam int DW = 8;
   localparam int TW = CH * DW;
   localparam int MR = 3;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          hs_req = 1'b0;
   logic [TW-1:0] datos_a = '0;
   logic [CH-1:0] ch_mask = '0;
   logic          hs_ack;
   logic [TW-1:0] datos_o;
   logic          busy;
   logic          snap_valid;
   logic          snap_err;
   logic [CW-1:0] snap_count;

   int tests_run = 0;
   int tests_failed = 0;

   logic [TW-1:0] seq [0:7];
   logic [TW-1:0] exp_o = '0;
   logic [CW-1:0] exp_count = '0;
   logic          exp_valid = 1'b0;
   logic          exp_err = 1'b0;

   always #5 clk = ~clk;

   hs_snapshot_n #(
      .CH_COUNT  (CH),
      .DATA_W    (DW),
      .MAX_RETRY (MR),
      .CNT_W     (CW),
      .MODE      (MODE_REQACK)
   ) dut (
      .reloj_nex  (clk),
      .reset      (reset),
      .datos_a    (datos_a),
      .ch_mask    (ch_mask),
      .hs_req     (hs_req),
      .hs_ack     (hs_ack),
      .datos_o    (datos_o),
      .busy       (busy),
      .snap_valid (snap_valid),
      .snap_err   (snap_err),
      .snap_count (snap_count)
   );

   task automatic checkOutput(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [TW-1:0] expand(input logic [CH-1:0] m);
      logic [TW-1:0] r;
      for (int i = 0; i < CH; i++) r[i*DW +: DW] = {DW{m[i]}};
      return r;
   endfunction

   function automatic logic [TW-1:0] fill(input logic [DW-1:0] b);
      return {CH{b}};
   endfunction

   task automatic checkState(input string tag);
      checkOutput({tag, " datos_o"}, datos_o, exp_o);
      checkOutput({tag, " count"}, TW'(snap_count), TW'(exp_count));
      checkOutput({tag, " valid"}, TW'(snap_valid), TW'(exp_valid));
      checkOutput({tag, " err"}, TW'(snap_err), TW'(exp_err));
   endtask

   // One capture of seq[] (value present at edge k after the rise edge).
   // pat 0: hold req until acked; 1: drop req right after the rise;
   // 2: drop req for the commit edge only, re-raise it during ACK_HOLD.
   task automatic applyStimulus(input logic [CH-1:0] m, input int pat, input string name);
      int            lat;
      logic [TW-1:0] mb;
      logic [TW-1:0] shad;
      logic          err;
      mb   = expand(m);
      lat  = 0;
      shad = seq[1];
      err  = 1'b0;
      // Two agreeing consecutive samples commit the older one; after MR
      // re-samples the newest one is committed with the error flag.
      for (int k = 2; k <= 2 + MR; k++) begin
         if (lat == 0) begin
            if ((seq[k] & mb) == (seq[k-1] & mb)) begin
               lat = k + 1; shad = seq[k-1]; err = 1'b0;
            end else if (k == 2 + MR) begin
               lat = k + 1; shad = seq[k]; err = 1'b1;
            end
         end
      end
      ch_mask = m;
      datos_a = seq[0];
      hs_req  = 1'b1;
      for (int k = 0; k < lat; k++) begin
         @(posedge clk); #1;
         datos_a = seq[k+1];
         if (pat == 1 && k == 0) hs_req = 1'b0;
         if (pat == 2 && k == lat - 1) hs_req = 1'b0;
         checkOutput({name, " ack early"}, TW'(hs_ack), '0);
         checkOutput({name, " busy"}, TW'(busy), TW'(1));
      end
      @(posedge clk); #1;
      exp_o     = (exp_o & ~mb) | (shad & mb);
      exp_count = exp_count + 1'b1;
      exp_valid = 1'b1;
      exp_err   = err;
      checkOutput({name, " ack commit"}, TW'(hs_ack), TW'(1));
      checkState({name, " commit"});
      if (pat == 2) hs_req = 1'b1;
      if (pat != 1) begin
         repeat (2) begin
            @(posedge clk); #1;
            checkOutput({name, " ack hold"}, TW'(hs_ack), TW'(1));
         end
         hs_req = 1'b0;
      end
      @(posedge clk); #1;
      checkOutput({name, " ack drop"}, TW'(hs_ack), '0);
      checkOutput({name, " idle busy"}, TW'(busy), '0);
      checkState({name, " after"});
   endtask

   task automatic randomSeq();
      int ch;
      seq[0] = {$urandom, $urandom, $urandom};
      for (int k = 1; k < 8; k++) begin
         seq[k] = seq[k-1];
         if (k <= 6 && $urandom_range(0, 2) == 0) begin
            ch = $urandom_range(0, CH - 1);
            seq[k][ch*DW +: DW] = seq[k][ch*DW +: DW] ^ DW'($urandom_range(1, 255));
         end
      end
   endtask

   initial begin
      logic [CH-1:0] m;
      repeat (2) @(posedge clk);
      #1;
      checkState("reset");
      checkOutput("reset ack", TW'(hs_ack), '0);
      checkOutput("reset busy", TW'(busy), '0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int k = 0; k < 8; k++) seq[k] = fill(8'h59);
      applyStimulus(12'hFFF, 0, "stable");

      for (int k = 0; k < 8; k++) seq[k] = fill(8'h59);
      for (int k = 2; k < 8; k++) seq[k][8*DW +: DW] = 8'h00;
      applyStimulus(12'hFFF, 0, "rollover");

      for (int k = 0; k < 8; k++) begin
         seq[k] = fill(8'h59);
         if (k >= 1) seq[k][7:0] = 8'h60 + 8'(k);
      end
      applyStimulus(12'hFFF, 1, "exhaust");

      for (int k = 0; k < 8; k++) seq[k] = fill(8'h11);
      applyStimulus(12'hFFF, 0, "prefill");
      for (int k = 0; k < 8; k++) seq[k] = fill(8'hAA);
      applyStimulus(12'h007, 0, "partial");

      for (int k = 0; k < 8; k++) seq[k] = fill(8'h3C);
      applyStimulus(12'h000, 2, "nomask");

      // Reset lands while the FSM sits in SAMPLE_B with the request still high.
      for (int k = 0; k < 8; k++) seq[k] = fill(8'h33);
      ch_mask = 12'hFFF;
      datos_a = seq[0];
      hs_req  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset     = 1'b0;
      exp_o     = '0;
      exp_count = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      checkState("midreset");
      checkOutput("midreset ack", TW'(hs_ack), '0);
      checkOutput("midreset busy", TW'(busy), '0);
      repeat (4) begin
         @(posedge clk); #1;
         checkOutput("held req busy", TW'(busy), '0);
         checkOutput("held req ack", TW'(hs_ack), '0);
      end
      checkState("held req");
      hs_req = 1'b0;
      @(posedge clk); #1;
      applyStimulus(12'hFFF, 0, "post reset");

      for (int n = 0; n < 255; n++) begin
         randomSeq();
         case ($urandom_range(0, 5))
            0:       m = '0;
            1:       m = '1;
            default: m = CH'($urandom);
         endcase
         applyStimulus(m, int'($urandom_range(0, 2)), "random");
      end
      checkOutput("wrap count", TW'(snap_count), '0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
